pipe_regfile: RTL and testbench

PIPE_REGFILE -- requirements
Module: pipe_regfile

---
 rtl/pipe_regfile_if.sv | 31 +++
 rtl/pipe_regfile.sv | 82 ++++++++
 tb/tb_pipe_regfile.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_regfile_if.sv
// Bundle of the register-file write, read, issue and scoreboard signals.
// The master side drives the requests and the slave side is the register file.
interface pipe_regfile_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic [AW-1:0]   rs1_addr;
    logic [XLEN-1:0] rs1_data;
    logic            rs1_busy;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs2_data;
    logic            rs2_busy;
    logic            iss_en;
    logic [AW-1:0]   iss_rd;
    logic [NREG-1:0] busy_vec;

    modport master (
        output we, waddr, wdata, rs1_addr, rs2_addr, iss_en, iss_rd,
        input  rs1_data, rs1_busy, rs2_data, rs2_busy, busy_vec
    );

    modport slave (
        input  we, waddr, wdata, rs1_addr, rs2_addr, iss_en, iss_rd,
        output rs1_data, rs1_busy, rs2_data, rs2_busy, busy_vec
    );
endinterface

// File: rtl/pipe_regfile.sv
// Two-read/one-write register file with registered reads and a pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module pipe_regfile #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst,
    pipe_regfile_if.slave bus
);
    localparam int AW    = $clog2(NREG);
    localparam int PORTS = 2;

    logic [XLEN-1:0]             regs [NREG];
    logic [NREG-1:0]             busy;
    logic [NREG-1:0]             busy_nxt;
    logic                        wr_ok;
    logic                        iss_ok;
    logic [PORTS-1:0][AW-1:0]    ra;
    logic [PORTS-1:0][XLEN-1:0]  rd_q;
    logic [PORTS-1:0][XLEN-1:0]  rd_nxt;
    logic [PORTS-1:0]            rd_busy;

    assign wr_ok  = bus.we     && !((ZERO_REG != 0) && (bus.waddr  == '0));
    assign iss_ok = bus.iss_en && !((ZERO_REG != 0) && (bus.iss_rd == '0));

    assign ra[0] = bus.rs1_addr;
    assign ra[1] = bus.rs2_addr;

    // Set is applied after clear so a same-index issue keeps the bit pending.
    always_comb begin
        busy_nxt = busy;
        if (bus.we) busy_nxt[bus.waddr] = 1'b0;
        if (iss_ok) busy_nxt[bus.iss_rd] = 1'b1;
    end

    for (genvar p = 0; p < PORTS; p++) begin : g_port
        logic hw0;
        logic byp;
        logic iss_hit;

        assign hw0     = (ZERO_REG != 0) && (ra[p] == '0);
        assign iss_hit = iss_ok && (bus.iss_rd == ra[p]);
`ifdef REGFILE_BYPASS_EN
        assign byp = wr_ok && (bus.waddr == ra[p]);
`else
        assign byp = 1'b0;
`endif

        always_comb begin
            rd_nxt[p] = regs[ra[p]];
            if (hw0)      rd_nxt[p] = '0;
            else if (byp) rd_nxt[p] = bus.wdata;
        end

        // A forwarded write retires the pending bit early unless it is re-issued now.
        always_comb begin
            rd_busy[p] = busy[ra[p]];
            if (hw0)      rd_busy[p] = 1'b0;
            else if (byp) rd_busy[p] = iss_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            busy <= '0;
            rd_q <= '0;
        end else begin
            if (wr_ok) regs[bus.waddr] <= bus.wdata;
            busy <= busy_nxt;
            rd_q <= rd_nxt;
        end
    end

    assign bus.rs1_data = rd_q[0];
    assign bus.rs2_data = rd_q[1];
    assign bus.rs1_busy = rd_busy[0];
    assign bus.rs2_busy = rd_busy[1];
    assign bus.busy_vec = busy;
endmodule

// File: tb/tb_pipe_regfile.sv
// Directed bench for pipe_regfile: a vector table plus hand sequences for reset,
// x0, latency, scoreboard, forwarding and a 64-bit/16-entry parameter build.
module tb_pipe_regfile;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_regfile_if #(.XLEN(32), .NREG(32)) bus ();
    pipe_regfile_if #(.XLEN(64), .NREG(16)) bus2 ();

    pipe_regfile #(.XLEN(32), .NREG(32), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    pipe_regfile #(.XLEN(64), .NREG(16), .ZERO_REG(0)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    int n_cmp = 0;
    int n_bad = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        iss;
        logic [4:0]  ird;
        logic        eb1;
        logic        eb2;
        logic [31:0] ed1;
        logic [31:0] ed2;
        logic [31:0] ebv;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drv(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic iss, input logic [4:0] ird);
        bus.we = we; bus.waddr = wa; bus.wdata = wd;
        bus.rs1_addr = r1; bus.rs2_addr = r2;
        bus.iss_en = iss; bus.iss_rd = ird;
    endtask

    task automatic drv2(input logic we, input logic [3:0] wa, input logic [63:0] wd,
                        input logic [3:0] r1, input logic [3:0] r2,
                        input logic iss, input logic [3:0] ird);
        bus2.we = we; bus2.waddr = wa; bus2.wdata = wd;
        bus2.rs1_addr = r1; bus2.rs2_addr = r2;
        bus2.iss_en = iss; bus2.iss_rd = ird;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           we wa  wdata         r1  r2  iss ird  eb1 eb2 ed1           ed2           ebv
        tbl[0] = '{1'b1, 5'd1,  32'h11111111, 5'd0,  5'd3,  1'b1, 5'd2,  1'b0, 1'b0, 32'h0,        32'h0,        32'h00000004};
        tbl[1] = '{1'b1, 5'd3,  32'h33333333, 5'd1,  5'd2,  1'b1, 5'd5,  1'b0, 1'b1, 32'h11111111, 32'h0,        32'h00000024};
        tbl[2] = '{1'b1, 5'd2,  32'h22222222, 5'd5,  5'd3,  1'b0, 5'd0,  1'b1, 1'b0, 32'h0,        32'h33333333, 32'h00000020};
        tbl[3] = '{1'b0, 5'd0,  32'h0,        5'd2,  5'd2,  1'b1, 5'd31, 1'b0, 1'b0, 32'h22222222, 32'h22222222, 32'h80000020};
        tbl[4] = '{1'b1, 5'd31, 32'hFFFF0000, 5'd5,  5'd1,  1'b1, 5'd0,  1'b1, 1'b0, 32'h0,        32'h11111111, 32'h00000020};
        tbl[5] = '{1'b1, 5'd5,  32'h55555555, 5'd31, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 32'hFFFF0000, 32'h0,        32'h00000000};
        tbl[6] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 1'b1, 5'd5,  1'b0, 1'b0, 32'h55555555, 32'hFFFF0000, 32'h00000020};

        rst = 1'b1;
        drv(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
        drv2(1'b0, 4'd0, 64'h0, 4'd0, 4'd0, 1'b0, 4'd0);
        step();
        step();
        chk("rst_rs1_data", bus.rs1_data, 0);
        chk("rst_rs2_data", bus.rs2_data, 0);
        chk("rst_busy_vec", bus.busy_vec, 0);
        chk("rst_busy_vec2", bus2.busy_vec, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            drv(tbl[i].we, tbl[i].waddr, tbl[i].wdata, tbl[i].ra1, tbl[i].ra2, tbl[i].iss, tbl[i].ird);
            #1;
            chk($sformatf("v%0d_rs1_busy", i), bus.rs1_busy, tbl[i].eb1);
            chk($sformatf("v%0d_rs2_busy", i), bus.rs2_busy, tbl[i].eb2);
            step();
            chk($sformatf("v%0d_rs1_data", i), bus.rs1_data, tbl[i].ed1);
            chk($sformatf("v%0d_rs2_data", i), bus.rs2_data, tbl[i].ed2);
            chk($sformatf("v%0d_busy_vec", i), bus.busy_vec, tbl[i].ebv);
        end

        // Reset mid-operation with a write and an issue in the reset cycle
        drv(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b1, 5'd5);
        step();
        rst = 1'b1;
        drv(1'b1, 5'd6, 32'h12340000, 5'd5, 5'd6, 1'b1, 5'd7);
        step();
        chk("midrst_rs1_data", bus.rs1_data, 0);
        chk("midrst_rs2_data", bus.rs2_data, 0);
        chk("midrst_busy_vec", bus.busy_vec, 0);
        rst = 1'b0;
        drv(1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 1'b0, 5'd0);
        #1;
        chk("postrst_rs1_busy", bus.rs1_busy, 0);
        step();
        chk("postrst_x5", bus.rs1_data, 0);
        chk("postrst_x6", bus.rs2_data, 0);

        // Hardwired x0
        drv(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 5'd0);
        #1;
        chk("x0_rs1_busy", bus.rs1_busy, 0);
        step();
        chk("x0_busy_vec", bus.busy_vec, 0);
        chk("x0_same_cycle_read", bus.rs1_data, 0);
        drv(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
        step();
        chk("x0_read", bus.rs1_data, 0);

        // Read latency
        drv(1'b1, 5'd3, 32'h12345678, 5'd0, 5'd0, 1'b0, 5'd0);
        step();
        drv(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b0, 5'd0);
        step();
        chk("lat_rs1_data", bus.rs1_data, 32'h12345678);
        chk("lat_rs2_data", bus.rs2_data, 32'h12345678);

        // Scoreboard: re-issue, set-wins, different-index set/clear
        drv(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd7);
        step();
        chk("sb_issue", bus.busy_vec, 32'h00000080);
        step();
        chk("sb_reissue", bus.busy_vec, 32'h00000080);
        drv(1'b1, 5'd7, 32'hA5A5A5A5, 5'd0, 5'd0, 1'b1, 5'd7);
        step();
        chk("sb_set_wins", bus.busy_vec, 32'h00000080);
        drv(1'b1, 5'd7, 32'h0F0F0F0F, 5'd7, 5'd0, 1'b1, 5'd8);
        #1;
        chk("sb_fwd_busy", bus.rs1_busy, BYP ? 1'b0 : 1'b1);
        step();
        chk("sb_diff_idx", bus.busy_vec, 32'h00000100);
        chk("sb_fwd_data", bus.rs1_data, BYP ? 32'h0F0F0F0F : 32'hA5A5A5A5);

        // Same-cycle write/read of x9
        drv(1'b1, 5'd9, 32'h11, 5'd0, 5'd0, 1'b0, 5'd0);
        step();
        drv(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd9);
        step();
        chk("x9_busy_vec", bus.busy_vec, 32'h00000300);
        drv(1'b1, 5'd9, 32'h55, 5'd0, 5'd9, 1'b0, 5'd0);
        #1;
        chk("x9_rs2_busy", bus.rs2_busy, BYP ? 1'b0 : 1'b1);
        step();
        chk("x9_rs2_data", bus.rs2_data, BYP ? 32'h55 : 32'h11);
        chk("x9_cleared", bus.busy_vec, 32'h00000100);
        drv(1'b0, 5'd0, 32'h0, 5'd0, 5'd9, 1'b0, 5'd0);
        step();
        chk("x9_after", bus.rs2_data, 32'h55);

        // 64-bit, 16-entry build without a hardwired zero register
        drv(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
        drv2(1'b1, 4'd0, 64'hCAFEBABE01234567, 4'd0, 4'd0, 1'b1, 4'd0);
        step();
        chk("p2_x0_busy_vec", bus2.busy_vec, 16'h0001);
        drv2(1'b1, 4'd15, 64'h8000000000000001, 4'd0, 4'd0, 1'b0, 4'd0);
        #1;
        chk("p2_x0_rs1_busy", bus2.rs1_busy, 1'b1);
        step();
        chk("p2_x0_data", bus2.rs1_data, 64'hCAFEBABE01234567);
        chk("p2_busy_vec", bus2.busy_vec, 16'h0001);
        drv2(1'b0, 4'd0, 64'h0, 4'd0, 4'd15, 1'b0, 4'd0);
        step();
        chk("p2_x15_data", bus2.rs2_data, 64'h8000000000000001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
